// File: rtl/anspwm_pkg.sv
// rtl/anspwm_pkg.sv - shared types and defaults for the PWM duty update scheduler
package anspwm_pkg;

  localparam int N_STAGES_DEF = 4;
  localparam int TW_DEF       = 32;
  localparam int DW_DEF       = 16;
  localparam int TIMEOUT_DEF  = 255;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STAGE = 2'd1,
    SUM   = 2'd2,
    HOLD  = 2'd3
  } sched_state_e;

  typedef logic [$clog2(N_STAGES_DEF)-1:0] stage_idx_t;

endpackage

// File: rtl/stage_watchdog.sv
// rtl/stage_watchdog.sv - per-stage down-counter that flags a stage taking too long
module stage_watchdog
  import anspwm_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  input  logic en,
  output logic expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  // Loading TIMEOUT-1 gives exactly TIMEOUT enabled cycles before expiry.
  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = CW'(TIMEOUT - 1);
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= CW'(TIMEOUT - 1);
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = en && (cnt_q == '0);

endmodule

// File: rtl/dsp_update_sched.sv
// rtl/dsp_update_sched.sv - sequences DSP stages per target request and commits the sum to PWM duty on a period boundary
module dsp_update_sched
  import anspwm_pkg::*;
#(
  parameter int             N_STAGES = N_STAGES_DEF,
  parameter int             TW       = TW_DEF,
  parameter int             DW       = DW_DEF,
  parameter int             TIMEOUT  = TIMEOUT_DEF,
  parameter logic [DW-1:0]  DUTY_RST = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  input  logic [TW-1:0]       req_target,
  output logic [TW-1:0]       tgt_out,
  output logic [N_STAGES-1:0] stage_en,
  input  logic                stage_done,
  input  logic [DW-1:0]       sum_in,
  input  logic                period_end,
  output logic [DW-1:0]       duty_out,
  output logic                duty_upd,
  output logic                busy,
  output logic                err_timeout
);

  localparam int IW = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;

  sched_state_e        state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [N_STAGES-1:0] stage_en_q, stage_en_d;
  logic [TW-1:0]       tgt_q, tgt_d;
  logic [TW-1:0]       pend_tgt_q, pend_tgt_d;
  logic                pend_q, pend_d;
  logic [DW-1:0]       shadow_q, shadow_d;
  logic [DW-1:0]       duty_q, duty_d;
  logic                duty_upd_q, duty_upd_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;
  logic                wd_restart, wd_en, wd_expired;

  // Counter reloads while idle and on every stage handoff, so each stage gets a fresh budget.
  assign wd_restart = (state_q == IDLE) || stage_done;
  assign wd_en      = (state_q == STAGE);

  stage_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (wd_restart),
    .en      (wd_en),
    .expired (wd_expired)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    tgt_d      = tgt_q;
    pend_d     = pend_q;
    pend_tgt_d = pend_tgt_q;
    shadow_d   = shadow_q;
    duty_d     = duty_q;
    duty_upd_d = 1'b0;
    err_d      = err_q;

    // Depth-1 pending slot: the newest request while busy replaces any older one.
    if ((state_q != IDLE) && req_valid) begin
      pend_d     = 1'b1;
      pend_tgt_d = req_target;
    end

    unique case (state_q)
      IDLE: begin
        if (req_valid || pend_q) begin
          tgt_d   = req_valid ? req_target : pend_tgt_q;
          pend_d  = 1'b0;
          idx_d   = '0;
          state_d = STAGE;
        end
      end
      STAGE: begin
        if (stage_done) begin
          if (idx_q == IW'(N_STAGES - 1)) begin
            state_d = SUM;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else if (wd_expired) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      SUM: begin
        shadow_d = sum_in;
        state_d  = HOLD;
      end
      HOLD: begin
        if (period_end) begin
          duty_d     = shadow_q;
          duty_upd_d = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Enables are derived from next state so they are registered yet line up with state.
    stage_en_d = (state_d == STAGE) ? (N_STAGES'(1) << idx_d) : '0;
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      stage_en_q <= '0;
      tgt_q      <= '0;
      pend_q     <= 1'b0;
      pend_tgt_q <= '0;
      shadow_q   <= DUTY_RST;
      duty_q     <= DUTY_RST;
      duty_upd_q <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      stage_en_q <= stage_en_d;
      tgt_q      <= tgt_d;
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
      shadow_q   <= shadow_d;
      duty_q     <= duty_d;
      duty_upd_q <= duty_upd_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  assign tgt_out     = tgt_q;
  assign stage_en    = stage_en_q;
  assign duty_out    = duty_q;
  assign duty_upd    = duty_upd_q;
  assign busy        = busy_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_dsp_update_sched.sv
// tb/tb_dsp_update_sched.sv - directed self-checking bench for dsp_update_sched
module tb_dsp_update_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [31:0] req_target = '0;
  logic [31:0] tgt_out;
  logic [3:0]  stage_en;
  logic        stage_done = 1'b0;
  logic [15:0] sum_in = '0;
  logic        period_end = 1'b0;
  logic [15:0] duty_out;
  logic        duty_upd;
  logic        busy;
  logic        err_timeout;

  int n_cmp = 0;
  int n_err = 0;
  int upd_cnt = 0;
  int exp_upd = 0;
  logic seen_11 = 1'b0;

  always #10 clk = ~clk;

  dsp_update_sched u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_target  (req_target),
    .tgt_out     (tgt_out),
    .stage_en    (stage_en),
    .stage_done  (stage_done),
    .sum_in      (sum_in),
    .period_end  (period_end),
    .duty_out    (duty_out),
    .duty_upd    (duty_upd),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  always @(negedge clk) begin
    if (duty_upd) upd_cnt++;
    if (tgt_out == 32'h4995CD11) seen_11 = 1'b1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic stage_step(input int k, input int delay, input logic [31:0] exp_tgt);
    check_eq($sformatf("stage_en[%0d]", k), {28'b0, stage_en}, 32'(1) << k);
    check_eq($sformatf("tgt_out[%0d]", k), tgt_out, exp_tgt);
    repeat (delay) tick();
    check_eq($sformatf("stage_hold[%0d]", k), {28'b0, stage_en}, 32'(1) << k);
    stage_done = 1'b1;
    tick();
    stage_done = 1'b0;
  endtask

  task automatic request(input logic [31:0] t);
    req_valid  = 1'b1;
    req_target = t;
    tick();
    req_valid  = 1'b0;
  endtask

  initial begin
    // reset state
    tick();
    tick();
    check_eq("rst_stage_en", {28'b0, stage_en}, 32'h0);
    check_eq("rst_duty", {16'b0, duty_out}, 32'h0);
    check_eq("rst_flags", {28'b0, duty_upd, busy, err_timeout, 1'b0}, 32'h0);
    check_eq("rst_tgt", tgt_out, 32'h0);
    rst_n = 1'b1;
    tick();

    // basic sequence
    sum_in = 16'h1234;
    request(32'h4995CD80);
    check_eq("basic_busy", {31'b0, busy}, 32'h1);
    for (int k = 0; k < 4; k++) stage_step(k, 3, 32'h4995CD80);
    check_eq("basic_sum_en", {28'b0, stage_en}, 32'h0);
    check_eq("basic_sum_busy", {31'b0, busy}, 32'h1);
    tick();
    repeat (10) tick();
    check_eq("basic_pre_duty", {16'b0, duty_out}, 32'h0);
    check_eq("basic_pre_upd", {31'b0, duty_upd}, 32'h0);
    period_end = 1'b1;
    tick();
    period_end = 1'b0;
    check_eq("basic_duty", {16'b0, duty_out}, 32'h1234);
    check_eq("basic_upd", {31'b0, duty_upd}, 32'h1);
    check_eq("basic_idle", {31'b0, busy}, 32'h0);
    tick();
    check_eq("basic_upd_low", {31'b0, duty_upd}, 32'h0);
    repeat (3) tick();
    exp_upd = 1;
    check_eq("basic_upd_cnt", upd_cnt, exp_upd);

    // overlapping requests; the 0x11 request coincides with a stage_done
    sum_in = 16'h5555;
    request(32'h4995CD80);
    check_eq("ovl_s0", {28'b0, stage_en}, 32'h1);
    tick();
    stage_done = 1'b1;
    req_valid  = 1'b1;
    req_target = 32'h4995CD11;
    tick();
    stage_done = 1'b0;
    req_valid  = 1'b0;
    check_eq("ovl_s1", {28'b0, stage_en}, 32'h2);
    tick();
    req_valid  = 1'b1;
    req_target = 32'h4995CD22;
    tick();
    req_valid  = 1'b0;
    stage_step(1, 0, 32'h4995CD80);
    stage_step(2, 1, 32'h4995CD80);
    stage_step(3, 1, 32'h4995CD80);
    tick();
    period_end = 1'b1;
    tick();
    period_end = 1'b0;
    check_eq("ovl_duty", {16'b0, duty_out}, 32'h5555);
    check_eq("ovl_tgt_commit", tgt_out, 32'h4995CD80);
    tick();
    check_eq("ovl_restart_en", {28'b0, stage_en}, 32'h1);
    check_eq("ovl_new_tgt", tgt_out, 32'h4995CD22);

    // period_end during STAGE and SUM is ignored
    sum_in = 16'h0ABC;
    period_end = 1'b1;
    for (int k = 0; k < 4; k++) stage_step(k, 1, 32'h4995CD22);
    tick();
    period_end = 1'b0;
    check_eq("bnd_hold_duty", {16'b0, duty_out}, 32'h5555);
    check_eq("bnd_hold_busy", {31'b0, busy}, 32'h1);
    repeat (3) tick();
    check_eq("bnd_wait_duty", {16'b0, duty_out}, 32'h5555);
    period_end = 1'b1;
    tick();
    period_end = 1'b0;
    check_eq("bnd_duty", {16'b0, duty_out}, 32'h0ABC);
    repeat (2) tick();
    exp_upd = 3;
    check_eq("bnd_upd_cnt", upd_cnt, exp_upd);
    check_eq("ovl_never_11", {31'b0, seen_11}, 32'h0);

    // timeout on stage 2
    request(32'h00007777);
    stage_step(0, 0, 32'h00007777);
    stage_step(1, 2, 32'h00007777);
    check_eq("to_stage2", {28'b0, stage_en}, 32'h4);
    repeat (254) tick();
    check_eq("to_last_en", {28'b0, stage_en}, 32'h4);
    check_eq("to_last_err", {31'b0, err_timeout}, 32'h0);
    tick();
    check_eq("to_en_off", {28'b0, stage_en}, 32'h0);
    check_eq("to_err", {31'b0, err_timeout}, 32'h1);
    check_eq("to_idle", {31'b0, busy}, 32'h0);
    check_eq("to_duty", {16'b0, duty_out}, 32'h0ABC);
    repeat (3) tick();
    sum_in = 16'h0F0F;
    request(32'h00001111);
    for (int k = 0; k < 4; k++) stage_step(k, 0, 32'h00001111);
    tick();
    period_end = 1'b1;
    tick();
    period_end = 1'b0;
    check_eq("to_after_duty", {16'b0, duty_out}, 32'h0F0F);
    check_eq("to_err_sticky", {31'b0, err_timeout}, 32'h1);

    // back-to-back done
    tick();
    sum_in = 16'h00FF;
    request(32'h0000ABCD);
    stage_done = 1'b1;
    check_eq("b2b_en0", {28'b0, stage_en}, 32'h1);
    tick();
    check_eq("b2b_en1", {28'b0, stage_en}, 32'h2);
    tick();
    check_eq("b2b_en2", {28'b0, stage_en}, 32'h4);
    tick();
    check_eq("b2b_en3", {28'b0, stage_en}, 32'h8);
    tick();
    check_eq("b2b_sum_en", {28'b0, stage_en}, 32'h0);
    check_eq("b2b_sum_busy", {31'b0, busy}, 32'h1);
    stage_done = 1'b0;
    tick();
    period_end = 1'b1;
    tick();
    period_end = 1'b0;
    check_eq("b2b_duty", {16'b0, duty_out}, 32'h00FF);
    repeat (2) tick();
    exp_upd = 5;
    check_eq("b2b_upd_cnt", upd_cnt, exp_upd);

    // asynchronous reset mid-STAGE
    request(32'h00002222);
    tick();
    check_eq("rst_mid_en", {28'b0, stage_en}, 32'h1);
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_stage_en", {28'b0, stage_en}, 32'h0);
    check_eq("rst_mid_duty", {16'b0, duty_out}, 32'h0);
    check_eq("rst_mid_busy", {31'b0, busy}, 32'h0);
    check_eq("rst_mid_err", {31'b0, err_timeout}, 32'h0);
    check_eq("rst_mid_tgt", tgt_out, 32'h0);
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    check_eq("rst_post_busy", {31'b0, busy}, 32'h0);
    check_eq("rst_post_duty", {16'b0, duty_out}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
